// File: rtl/rf_wb_arbiter_pkg.sv
// Shared types for the register-file writeback arbiter.
// Default geometry of the RF write port and the arbiter FSM states.
package rf_pkg;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = $clog2(NREG);

  typedef logic [AW-1:0]   rf_addr_t;
  typedef logic [XLEN-1:0] rf_data_t;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } wb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: first request at or after ptr,
// scanning upward with wrap-around. One-hot grant plus its index.
module rr_arbiter
  import rf_pkg::*;
#(
  parameter int  N  = 3,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic found;
  int   idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter for the single RF write port; after every
// reset it sweeps x1..x(NREG-1) to zero before granting requesters.
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int  NREQ = 3,
  parameter int  XLEN = 32,
  parameter int  NREG = 32,
  localparam int AW   = $clog2(NREG)
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [NREQ-1:0]      req_valid_i,
  input  logic [NREQ*AW-1:0]   req_rd_i,
  input  logic [NREQ*XLEN-1:0] req_wd_i,
  output logic [NREQ-1:0]      req_ready_o,
  output logic              rf_regwrite_o,
  output logic [AW-1:0]     rf_rd_o,
  output logic [XLEN-1:0]   rf_wd_o,
  output logic              init_done_o
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  wb_state_e       state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic            we_q, we_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic [XLEN-1:0] wd_q, wd_d;
  logic            done_q, done_d;

  logic [NREQ-1:0] arb_req;
  logic [NREQ-1:0] gnt;
  logic [IW-1:0]   gnt_idx;
  logic            xfer;
  logic [AW-1:0]   sel_rd;
  logic [XLEN-1:0] sel_wd;

  // Requesters stay invisible to the arbiter until the sweep is over.
  assign arb_req = (state_q == RUN) ? req_valid_i : '0;

  rr_arbiter #(
    .N (NREQ)
  ) u_rr (
    .req     (arb_req),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign xfer        = |gnt;
  assign req_ready_o = gnt;
  assign sel_rd      = req_rd_i[int'(gnt_idx)*AW +: AW];
  assign sel_wd      = req_wd_i[int'(gnt_idx)*XLEN +: XLEN];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    we_d    = 1'b0;
    rd_d    = rd_q;
    wd_d    = wd_q;
    done_d  = done_q;
    unique case (state_q)
      CLEAR: begin
        we_d  = 1'b1;
        rd_d  = cnt_q;
        wd_d  = '0;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == AW'(NREG - 1)) begin
          state_d = RUN;
          done_d  = 1'b1;
        end
      end
      RUN: begin
        if (xfer) begin
          // x0 is hardwired: accept the transfer but suppress the write.
          we_d  = |sel_rd;
          rd_d  = sel_rd;
          wd_d  = sel_wd;
          ptr_d = (gnt_idx == IW'(NREQ - 1)) ? '0
                                             : gnt_idx + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= CLEAR;
      cnt_q   <= AW'(1);
      ptr_q   <= '0;
      we_q    <= 1'b0;
      rd_q    <= '0;
      wd_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      we_q    <= we_d;
      rd_q    <= rd_d;
      wd_q    <= wd_d;
      done_q  <= done_d;
    end
  end

  assign rf_regwrite_o = we_q;
  assign rf_rd_o       = rd_q;
  assign rf_wd_o       = wd_q;
  assign init_done_o   = done_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: clear sweep, arbitration
// table, x0 writes and reset during the sweep.
module tb_rf_wb_arbiter;

  localparam int NREQ = 3;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   reset_i;
  logic [NREQ-1:0]        valid;
  logic [NREQ*AW-1:0]     rd;
  logic [NREQ*XLEN-1:0]   wd;
  logic [NREQ-1:0]        ready;
  logic                   we;
  logic [AW-1:0]          rf_rd;
  logic [XLEN-1:0]        rf_wd;
  logic                   done;

  rf_wb_arbiter #(
    .NREQ (NREQ),
    .XLEN (XLEN),
    .NREG (NREG)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .req_valid_i   (valid),
    .req_rd_i      (rd),
    .req_wd_i      (wd),
    .req_ready_o   (ready),
    .rf_regwrite_o (we),
    .rf_rd_o       (rf_rd),
    .rf_wd_o       (rf_wd),
    .init_done_o   (done)
  );

  int passed = 0;
  int total  = 0;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h",
                  name, act, exp);
  endtask

  typedef struct {
    logic [NREQ-1:0]      valid;
    logic [NREQ*AW-1:0]   rd;
    logic [NREQ*XLEN-1:0] wd;
    logic [NREQ-1:0]      ready;
    logic                 we;
    logic [AW-1:0]        rf_rd;
    logic [XLEN-1:0]      rf_wd;
    logic                 chk_wd;
  } vec_t;

  vec_t vecs[$];

  localparam logic [NREQ*AW-1:0] RD_ALL =
    {5'd12, 5'd11, 5'd10};
  localparam logic [NREQ*XLEN-1:0] WD_ALL =
    {32'hA2, 32'hA1, 32'hA0};

  initial begin
    // rr_ptr is 0 when the table starts
    vecs.push_back('{3'b001, {5'd0, 5'd0, 5'd5},
      {32'h0, 32'h0, 32'hDEADBEEF},
      3'b001, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1});
    vecs.push_back('{3'b000, '0, '0,
      3'b000, 1'b0, 5'd5, 32'hDEADBEEF, 1'b1});
    vecs.push_back('{3'b011, {5'd0, 5'd6, 5'd7},
      {32'h0, 32'h66, 32'h77},
      3'b010, 1'b1, 5'd6, 32'h66, 1'b1});
    vecs.push_back('{3'b011, {5'd0, 5'd6, 5'd7},
      {32'h0, 32'h66, 32'h77},
      3'b001, 1'b1, 5'd7, 32'h77, 1'b1});
    vecs.push_back('{3'b100, {5'd3, 5'd0, 5'd0},
      {32'h33, 32'h0, 32'h0},
      3'b100, 1'b1, 5'd3, 32'h33, 1'b1});
    for (int r = 0; r < 2; r++) begin
      vecs.push_back('{3'b111, RD_ALL, WD_ALL,
        3'b001, 1'b1, 5'd10, 32'hA0, 1'b1});
      vecs.push_back('{3'b111, RD_ALL, WD_ALL,
        3'b010, 1'b1, 5'd11, 32'hA1, 1'b1});
      vecs.push_back('{3'b111, RD_ALL, WD_ALL,
        3'b100, 1'b1, 5'd12, 32'hA2, 1'b1});
    end
    vecs.push_back('{3'b010, {5'd0, 5'd0, 5'd0},
      {32'h0, 32'h1234, 32'h0},
      3'b010, 1'b0, 5'd0, 32'h0, 1'b0});
    vecs.push_back('{3'b111, RD_ALL, WD_ALL,
      3'b100, 1'b1, 5'd12, 32'hA2, 1'b1});
    vecs.push_back('{3'b111, RD_ALL, WD_ALL,
      3'b001, 1'b1, 5'd10, 32'hA0, 1'b1});
    vecs.push_back('{3'b000, '0, '0,
      3'b000, 1'b0, 5'd10, 32'hA0, 1'b1});

    reset_i = 1'b1;
    valid   = '0;
    rd      = '0;
    wd      = '0;
    @(posedge clk); #1;
    check("rst_we", we, 0);
    check("rst_rd", rf_rd, 0);
    check("rst_wd", rf_wd, 0);
    check("rst_done", done, 0);
    reset_i = 1'b0;

    for (int i = 1; i <= 31; i++) begin
      @(posedge clk); #1;
      check("sweep_we", we, 1);
      check("sweep_rd", rf_rd, i);
      check("sweep_wd", rf_wd, 0);
      check("sweep_done", done, (i == 31));
    end
    @(posedge clk); #1;
    check("post_sweep_we", we, 0);
    check("post_sweep_done", done, 1);

    for (int v = 0; v < vecs.size(); v++) begin
      valid = vecs[v].valid;
      rd    = vecs[v].rd;
      wd    = vecs[v].wd;
      #1;
      check($sformatf("v%0d_ready", v), ready, vecs[v].ready);
      @(posedge clk); #1;
      check($sformatf("v%0d_we", v), we, vecs[v].we);
      check($sformatf("v%0d_rd", v), rf_rd, vecs[v].rf_rd);
      if (vecs[v].chk_wd)
        check($sformatf("v%0d_wd", v), rf_wd, vecs[v].rf_wd);
    end

    // reset mid-RUN with req2 pending, then again mid-sweep
    reset_i = 1'b1;
    valid   = 3'b100;
    rd      = {5'd9, 10'd0};
    wd      = {32'h99, 64'd0};
    @(posedge clk); #1;
    check("rst2_we", we, 0);
    check("rst2_done", done, 0);
    check("rst2_ready", ready, 0);
    reset_i = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      @(posedge clk); #1;
      check("part_rd", rf_rd, i);
      check("part_ready", ready, 0);
    end
    reset_i = 1'b1;
    @(posedge clk); #1;
    check("midrst_we", we, 0);
    check("midrst_rd", rf_rd, 0);
    check("midrst_wd", rf_wd, 0);
    check("midrst_done", done, 0);
    check("midrst_ready", ready, 0);
    reset_i = 1'b0;
    for (int i = 1; i <= 31; i++) begin
      @(posedge clk); #1;
      check("resweep_we", we, 1);
      check("resweep_rd", rf_rd, i);
      check("resweep_ready", ready,
            (i == 31) ? 3'b100 : 3'b000);
    end
    @(posedge clk); #1;
    check("first_run_we", we, 1);
    check("first_run_rd", rf_rd, 9);
    check("first_run_wd", rf_wd, 32'h99);
    check("first_run_done", done, 1);
    valid = '0;
    @(posedge clk); #1;
    check("idle_we", we, 0);
    check("idle_rd_hold", rf_rd, 9);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
